// File: rtl/x2050_fp_align.sv
// x2050_fp_align: floating-point pre-normalization alignment sequencer.
// Right-shifts the smaller-exponent fraction one hex digit per clock,
// keeping a guard digit and a sticky flag, then pulses o_done.
//
// Ports:
//   i_clk, i_reset    clock, synchronous active-high reset
//   i_start           start request, sampled only in IDLE
//   i_frac            fraction to align
//   i_count           low hex digit of exponent difference
//   i_le16, i_zero    difference <= 15, difference == 0
//   o_frac, o_guard   aligned fraction, first digit shifted out
//   o_sticky          OR of nonzero digits shifted beyond the guard
//   o_busy, o_done    sequencer active, one-cycle result-valid pulse
//
// state  | meaning
// IDLE   | waiting for i_start
// SHIFT  | shifting one digit per clock, cnt digits remain
// DONE   | result valid, o_done high for this cycle
module x2050_fp_align #(
  parameter int FRAC_W = 24
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [FRAC_W-1:0] i_frac,
  input  logic [3:0]        i_count,
  input  logic              i_le16,
  input  logic              i_zero,
  output logic [FRAC_W-1:0] o_frac,
  output logic [3:0]        o_guard,
  output logic              o_sticky,
  output logic              o_busy,
  output logic              o_done
);

  localparam int D     = FRAC_W / 4;
  // Count must hold D+1, the saturated shift amount.
  localparam int CNT_W = $clog2(D + 2);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [FRAC_W-1:0] frac_q, frac_d;
  logic [3:0]        guard_q, guard_d;
  logic              sticky_q, sticky_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [4:0]        e_raw;
  logic [CNT_W-1:0]  e_sat;

  // Effective shift count. Beyond D+1 digits everything has already left
  // both the fraction and the guard, so further shifting changes nothing.
  always_comb begin
    if (i_zero) begin
      e_raw = 5'd0;
    end else if (!i_le16) begin
      e_raw = 5'd16;
    end else begin
      e_raw = {1'b0, i_count};
    end
    if (int'(e_raw) > D + 1) begin
      e_sat = CNT_W'(D + 1);
    end else begin
      e_sat = CNT_W'(e_raw);
    end
  end

  always_comb begin
    state_d  = state_q;
    frac_d   = frac_q;
    guard_d  = guard_q;
    sticky_d = sticky_q;
    cnt_d    = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          frac_d   = i_frac;
          guard_d  = 4'd0;
          sticky_d = 1'b0;
          cnt_d    = e_sat;
          state_d  = (e_sat == '0) ? ST_DONE : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        frac_d   = {4'd0, frac_q[FRAC_W-1:4]};
        guard_d  = frac_q[3:0];
        sticky_d = sticky_q | (|guard_q);
        cnt_d    = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= ST_IDLE;
      frac_q   <= '0;
      guard_q  <= 4'd0;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      frac_q   <= frac_d;
      guard_q  <= guard_d;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
    end
  end

  assign o_frac   = frac_q;
  assign o_guard  = guard_q;
  assign o_sticky = sticky_q;
  assign o_busy   = (state_q != ST_IDLE);
  assign o_done   = (state_q == ST_DONE);

endmodule

// File: tb/tb_x2050_fp_align.sv
// Self-checking bench for x2050_fp_align: one short (24-bit) and one long
// (56-bit) instance, directed cases plus randomized operations compared
// against a digit-level reference model.
module tb_x2050_fp_align;

  logic        clk;
  logic        rst;
  logic        s_start, l_start;
  logic [23:0] s_frac_in;
  logic [55:0] l_frac_in;
  logic [3:0]  cnt_in;
  logic        le16_in, zero_in;

  logic [23:0] s_frac;
  logic [55:0] l_frac;
  logic [3:0]  s_guard, l_guard;
  logic        s_sticky, l_sticky, s_busy, l_busy, s_done, l_done;

  int n_chk  = 0;
  int n_pass = 0;

  x2050_fp_align #(.FRAC_W(24)) u_short (
    .i_clk(clk), .i_reset(rst), .i_start(s_start), .i_frac(s_frac_in),
    .i_count(cnt_in), .i_le16(le16_in), .i_zero(zero_in),
    .o_frac(s_frac), .o_guard(s_guard), .o_sticky(s_sticky),
    .o_busy(s_busy), .o_done(s_done)
  );

  x2050_fp_align #(.FRAC_W(56)) u_long (
    .i_clk(clk), .i_reset(rst), .i_start(l_start), .i_frac(l_frac_in),
    .i_count(cnt_in), .i_le16(le16_in), .i_zero(zero_in),
    .o_frac(l_frac), .o_guard(l_guard), .o_sticky(l_sticky),
    .o_busy(l_busy), .o_done(l_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] obs_frac(input bit lng);
    return lng ? {8'd0, l_frac} : {40'd0, s_frac};
  endfunction
  function automatic logic [3:0] obs_guard(input bit lng);
    return lng ? l_guard : s_guard;
  endfunction
  function automatic logic obs_sticky(input bit lng);
    return lng ? l_sticky : s_sticky;
  endfunction
  function automatic logic obs_busy(input bit lng);
    return lng ? l_busy : s_busy;
  endfunction
  function automatic logic obs_done(input bit lng);
    return lng ? l_done : s_done;
  endfunction

  // Reference: treat the fraction as D hex digits, digit 0 least significant.
  // After e digit shifts, digit e-1 is the guard and digits below it are sticky.
  task automatic model(input bit lng, input logic [63:0] frac, input logic [3:0] cnt,
                       input bit le16, input bit zero, output int e,
                       output logic [63:0] f, output logic [3:0] g, output logic s);
    int d;
    logic [3:0] dig;
    d = lng ? 14 : 6;
    if (zero) e = 0;
    else if (!le16) e = 16;
    else e = int'(cnt);
    if (e > d + 1) e = d + 1;
    f = frac >> (4 * e);
    g = 4'd0;
    s = 1'b0;
    for (int i = 0; i < d; i++) begin
      dig = frac[4*i +: 4];
      if (i == e - 1) g = dig;
      else if (i < e - 1) s = s | (dig != 4'd0);
    end
  endtask

  task automatic drive_start(input bit lng, input logic [63:0] frac);
    if (lng) begin
      l_frac_in = frac[55:0];
      l_start   = 1'b1;
    end else begin
      s_frac_in = frac[23:0];
      s_start   = 1'b1;
    end
  endtask

  // Called away from the clock edge. Returns one cycle after o_done, in IDLE,
  // so a following call exercises back-to-back acceptance.
  task automatic run_op(input string tag, input bit lng, input logic [63:0] frac,
                        input logic [3:0] cnt, input bit le16, input bit zero,
                        input bit poke);
    int e, n;
    logic [63:0] ef;
    logic [3:0] eg;
    logic es;
    model(lng, frac, cnt, le16, zero, e, ef, eg, es);
    cnt_in  = cnt;
    le16_in = le16;
    zero_in = zero;
    drive_start(lng, frac);
    @(posedge clk); #1;
    s_start = 1'b0;
    l_start = 1'b0;
    cnt_in  = 4'($urandom);
    le16_in = 1'($urandom);
    zero_in = 1'($urandom);
    s_frac_in = 24'($urandom);
    l_frac_in = {24'($urandom), 32'($urandom)};
    n = 0;
    while (!obs_done(lng) && n < 40) begin
      if (poke && n == 0) drive_start(lng, 64'hFFFF_FFFF_FFFF_FFFF);
      @(posedge clk); #1;
      s_start = 1'b0;
      l_start = 1'b0;
      n++;
    end
    chk({tag, ".latency"}, 64'(n), 64'(e));
    chk({tag, ".frac"}, obs_frac(lng), ef);
    chk({tag, ".guard"}, 64'(obs_guard(lng)), 64'(eg));
    chk({tag, ".sticky"}, 64'(obs_sticky(lng)), 64'(es));
    chk({tag, ".busy"}, 64'(obs_busy(lng)), 64'd1);
    @(posedge clk); #1;
    chk({tag, ".done_pulse"}, 64'(obs_done(lng)), 64'd0);
    chk({tag, ".idle"}, 64'(obs_busy(lng)), 64'd0);
    chk({tag, ".hold"}, obs_frac(lng), ef);
  endtask

  initial begin
    int dones;
    logic [63:0] fr;
    bit lng;
    rst = 1'b1;
    s_start = 1'b0; l_start = 1'b0;
    s_frac_in = '0; l_frac_in = '0;
    cnt_in = 4'd0; le16_in = 1'b1; zero_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.s_frac", obs_frac(0), 64'd0);
    chk("rst.l_frac", obs_frac(1), 64'd0);
    chk("rst.s_busy", 64'(s_busy), 64'd0);
    chk("rst.s_done", 64'(s_done), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Reset in the third cycle of an operation aborts it silently.
    s_frac_in = 24'hABCDEF; cnt_in = 4'd5; le16_in = 1'b1; zero_in = 1'b0;
    s_start = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort.frac", obs_frac(0), 64'd0);
    chk("abort.guard", 64'(s_guard), 64'd0);
    chk("abort.sticky", 64'(s_sticky), 64'd0);
    chk("abort.busy", 64'(s_busy), 64'd0);
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      if (s_done) dones++;
      @(posedge clk); #1;
    end
    chk("abort.no_done", 64'(dones), 64'd0);

    run_op("zero_diff", 0, 64'h123456, 4'd3, 1'b1, 1'b1, 1'b0);
    run_op("two_digit", 0, 64'h123456, 4'd2, 1'b1, 1'b0, 1'b0);
    run_op("sat_short", 0, 64'h800001, 4'hA, 1'b1, 1'b0, 1'b0);
    run_op("sat_ge16", 0, 64'h000000, 4'h0, 1'b0, 1'b0, 1'b0);
    run_op("busy_poke", 0, 64'h0F0000, 4'd3, 1'b1, 1'b0, 1'b1);
    run_op("b2b", 0, 64'hFEDCBA, 4'd1, 1'b1, 1'b0, 1'b0);
    run_op("long_1", 1, 64'h10, 4'd1, 1'b1, 1'b0, 1'b0);
    run_op("long_ge16", 1, 64'h10, 4'd1, 1'b0, 1'b0, 1'b0);
    run_op("long_max", 1, 64'h00FF_FFFF_FFFF_FFFF, 4'hF, 1'b1, 1'b0, 1'b0);
    run_op("long_d", 1, 64'h0080_0000_0000_0000, 4'hE, 1'b1, 1'b0, 1'b0);

    for (int k = 0; k < 40; k++) begin
      lng = 1'($urandom);
      fr = {$urandom, $urandom};
      if ($urandom_range(0, 2) == 0) fr = fr & 64'hFFFF_FFFF_F000_0000;
      fr = lng ? (fr & 64'h00FF_FFFF_FFFF_FFFF) : (fr & 64'h0000_0000_00FF_FFFF);
      run_op("rand", lng, fr, 4'($urandom), ($urandom_range(0, 5) != 0),
             ($urandom_range(0, 7) == 0), 1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
